// File: rtl/agree_pht_pkg.sv
// ============================================================================
//  Module   : agree_pkg
//  Purpose  : Shared types, counter constants and the saturating-counter step
//             for the agree-predictor pattern history table.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package agree_pkg;

    typedef logic [1:0] agree_cnt_t;

    localparam agree_cnt_t CNT_WEAK_AGREE = 2'b10;
    localparam agree_cnt_t CNT_MAX        = 2'b11;
    localparam agree_cnt_t CNT_MIN        = 2'b00;

    // One training step: move toward "agree" or "disagree", clamping at the ends
    function automatic agree_cnt_t agree_sat_next(input agree_cnt_t cnt, input logic agree);
        agree_cnt_t nxt;
        nxt = cnt;
        if (agree) begin
            if (cnt != CNT_MAX) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_MIN) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/agree_pht_if.sv
// ============================================================================
//  Module   : agree_pht_if
//  Purpose  : Fetch-lookup and EX-update signal bundle of the agree PHT.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface agree_pht_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int GHR_WIDTH   = 8
);
    logic                   fetch_valid_i;
    logic                   stall_i;
    logic [31:0]            pc_i;
    logic                   btb_hit_i;
    logic                   bias_i;
    logic                   pred_taken_o;
    logic [INDEX_WIDTH-1:0] pred_index_o;
    logic [GHR_WIDTH-1:0]   ghr_o;
    logic                   upd_valid_i;
    logic                   upd_alloc_i;
    logic [INDEX_WIDTH-1:0] upd_index_i;
    logic                   upd_bias_i;
    logic                   upd_taken_i;
    logic                   upd_mispred_i;
    logic [GHR_WIDTH-1:0]   upd_ghr_i;

    modport master (
        output fetch_valid_i, stall_i, pc_i, btb_hit_i, bias_i,
        output upd_valid_i, upd_alloc_i, upd_index_i, upd_bias_i,
        output upd_taken_i, upd_mispred_i, upd_ghr_i,
        input  pred_taken_o, pred_index_o, ghr_o
    );

    modport slave (
        input  fetch_valid_i, stall_i, pc_i, btb_hit_i, bias_i,
        input  upd_valid_i, upd_alloc_i, upd_index_i, upd_bias_i,
        input  upd_taken_i, upd_mispred_i, upd_ghr_i,
        output pred_taken_o, pred_index_o, ghr_o
    );
endinterface

`default_nettype wire

// File: rtl/agree_pht_ghr.sv
// ============================================================================
//  Module   : agree_ghr
//  Purpose  : Speculative global history register with mispredict recovery.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module agree_ghr #(
    parameter int GHR_WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_shift_en,
    input  wire logic                 i_shift_bit,
    input  wire logic                 i_recover_en,
    input  wire logic [GHR_WIDTH-1:0] i_recover_ghr,
    input  wire logic                 i_recover_bit,
    output logic      [GHR_WIDTH-1:0] o_ghr
);

    logic [GHR_WIDTH-1:0] r_ghr;
    logic [GHR_WIDTH-1:0] w_spec_next;
    logic [GHR_WIDTH-1:0] w_recover_next;

    generate
        if (GHR_WIDTH == 1) begin : g_ghr_single
            logic w_unused_recover;
            assign w_unused_recover = i_recover_ghr[0];
            assign w_spec_next      = i_shift_bit;
            assign w_recover_next   = i_recover_bit;
        end else begin : g_ghr_shift
            // The oldest checkpointed bit falls off the end on recovery
            logic w_unused_msb;
            assign w_unused_msb   = i_recover_ghr[GHR_WIDTH-1];
            assign w_spec_next    = {r_ghr[GHR_WIDTH-2:0], i_shift_bit};
            assign w_recover_next = {i_recover_ghr[GHR_WIDTH-2:0], i_recover_bit};
        end
    endgenerate

    // Recovery overrides any same-cycle speculative shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (i_recover_en) begin
            r_ghr <= w_recover_next;
        end else if (i_shift_en) begin
            r_ghr <= w_spec_next;
        end
    end

    assign o_ghr = r_ghr;

endmodule

`default_nettype wire

// File: rtl/agree_pht.sv
// ============================================================================
//  Module   : agree_pht
//  Purpose  : Agree-predictor PHT: gshare-indexed 2-bit agree counters, final
//             taken prediction from BTB bias, speculative GHR with recovery.
//             Optional lookup/mispredict counters under AGREE_PHT_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module agree_pht
    import agree_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int GHR_WIDTH   = 8
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    agree_pht_if.slave  pht
`ifdef AGREE_PHT_STATS_EN
    ,
    output logic [31:0] stat_lookups_o,
    output logic [31:0] stat_mispred_o
`endif
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;

    agree_cnt_t             r_cnt [DEPTH];
    logic [GHR_WIDTH-1:0]   w_ghr;
    logic [INDEX_WIDTH-1:0] w_idx;
    logic                   w_agree;
    logic                   w_pred;
    logic                   w_spec_shift;
    logic                   w_recover;
    logic                   w_unused_pc;

    assign w_unused_pc  = ^{pht.pc_i[31:INDEX_WIDTH+2], pht.pc_i[1:0]};

    assign w_idx        = pht.pc_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(w_ghr);
    assign w_agree      = r_cnt[w_idx][1];
    assign w_pred       = pht.btb_hit_i & (w_agree ? pht.bias_i : ~pht.bias_i);
    assign w_spec_shift = pht.fetch_valid_i & pht.btb_hit_i & ~pht.stall_i;
    assign w_recover    = pht.upd_valid_i & pht.upd_mispred_i;

    assign pht.pred_taken_o = w_pred;
    assign pht.pred_index_o = w_idx;
    assign pht.ghr_o        = w_ghr;

    agree_ghr #(
        .GHR_WIDTH (GHR_WIDTH)
    ) u_ghr (
        .clk           (clk_i),
        .rst           (rst_i),
        .i_shift_en    (w_spec_shift),
        .i_shift_bit   (w_pred),
        .i_recover_en  (w_recover),
        .i_recover_ghr (pht.upd_ghr_i),
        .i_recover_bit (pht.upd_taken_i),
        .o_ghr         (w_ghr)
    );

    // Writes land at the edge; the lookup above sees pre-write contents
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= CNT_WEAK_AGREE;
            end
        end else if (pht.upd_valid_i) begin
            if (pht.upd_alloc_i) begin
                r_cnt[pht.upd_index_i] <= CNT_WEAK_AGREE;
            end else begin
                r_cnt[pht.upd_index_i] <= agree_sat_next(r_cnt[pht.upd_index_i],
                                                         pht.upd_taken_i == pht.upd_bias_i);
            end
        end
    end

`ifdef AGREE_PHT_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_lookups <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (w_spec_shift) r_stat_lookups <= r_stat_lookups + 32'd1;
            if (w_recover)    r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_lookups_o = r_stat_lookups;
    assign stat_mispred_o = r_stat_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_agree_pht.sv
// ============================================================================
//  Module   : tb_agree_pht
//  Purpose  : Self-checking bench for agree_pht: vector table, directed corner
//             sequences and random traffic against an array-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_agree_pht;

    localparam int IW    = 8;
    localparam int GW    = 8;
    localparam int DEPTH = 1 << IW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    agree_pht_if #(.INDEX_WIDTH(IW), .GHR_WIDTH(GW)) bus ();

`ifdef AGREE_PHT_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispred;
`endif

    agree_pht #(
        .INDEX_WIDTH (IW),
        .GHR_WIDTH   (GW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pht            (bus)
`ifdef AGREE_PHT_STATS_EN
        ,
        .stat_lookups_o (stat_lookups),
        .stat_mispred_o (stat_mispred)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: counter values 0..3 and history as an integer
    int       m_cnt [DEPTH];
    int       m_ghr;
    bit [31:0] m_lookups;
    bit [31:0] m_mispred;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic        bias;
        logic        exp_pred;
        logic [7:0]  exp_idx;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_idx();
        return (int'(bus.pc_i >> 2) % DEPTH) ^ m_ghr;
    endfunction

    function automatic int model_pred();
        if (!bus.btb_hit_i) return 0;
        return (m_cnt[model_idx()] >= 2) ? int'(bus.bias_i) : int'(!bus.bias_i);
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 2;
        m_ghr     = 0;
        m_lookups = '0;
        m_mispred = '0;
    endtask

    task automatic model_clock();
        int  pred;
        int  ui;
        bit  lookup;
        pred   = model_pred();
        lookup = bus.fetch_valid_i && bus.btb_hit_i && !bus.stall_i;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.upd_valid_i && bus.upd_mispred_i)
                m_ghr = ((int'(bus.upd_ghr_i) * 2) + int'(bus.upd_taken_i)) % (1 << GW);
            else if (lookup)
                m_ghr = ((m_ghr * 2) + pred) % (1 << GW);
            if (lookup) m_lookups++;
            if (bus.upd_valid_i && bus.upd_mispred_i) m_mispred++;
            if (bus.upd_valid_i) begin
                ui = int'(bus.upd_index_i);
                if (bus.upd_alloc_i)
                    m_cnt[ui] = 2;
                else if (bus.upd_taken_i == bus.upd_bias_i)
                    m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
                else
                    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
            end
        end
    endtask

    // Inputs are set just after a falling edge; compare, then clock both sides
    task automatic cycle();
        #1;
        check("pred_taken", 32'(bus.pred_taken_o), 32'(model_pred()));
        check("pred_index", 32'(bus.pred_index_o), 32'(model_idx()));
        check("ghr", 32'(bus.ghr_o), 32'(m_ghr));
`ifdef AGREE_PHT_STATS_EN
        check("stat_lookups", stat_lookups, m_lookups);
        check("stat_mispred", stat_mispred, m_mispred);
`endif
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.fetch_valid_i = 1'b0;
        bus.stall_i       = 1'b0;
        bus.pc_i          = '0;
        bus.btb_hit_i     = 1'b0;
        bus.bias_i        = 1'b0;
        bus.upd_valid_i   = 1'b0;
        bus.upd_alloc_i   = 1'b0;
        bus.upd_index_i   = '0;
        bus.upd_bias_i    = 1'b0;
        bus.upd_taken_i   = 1'b0;
        bus.upd_mispred_i = 1'b0;
        bus.upd_ghr_i     = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic train(input int idx, input logic bias, input logic taken, input int n);
        for (int k = 0; k < n; k++) begin
            idle();
            bus.upd_valid_i = 1'b1;
            bus.upd_index_i = IW'(idx);
            bus.upd_bias_i  = bias;
            bus.upd_taken_i = taken;
            cycle();
        end
        idle();
    endtask

    task automatic probe(input string name, input logic [31:0] pc, input logic bias, input logic exp);
        bus.pc_i      = pc;
        bus.btb_hit_i = 1'b1;
        bus.bias_i    = bias;
        #1;
        check(name, 32'(bus.pred_taken_o), 32'(exp));
        cycle();
        idle();
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0000_0100, hit: 1'b1, bias: 1'b1, exp_pred: 1'b1, exp_idx: 8'h40};
        vecs[1] = '{pc: 32'h0000_0100, hit: 1'b1, bias: 1'b0, exp_pred: 1'b0, exp_idx: 8'h40};
        vecs[2] = '{pc: 32'h0000_0104, hit: 1'b0, bias: 1'b1, exp_pred: 1'b0, exp_idx: 8'h41};
        vecs[3] = '{pc: 32'h0000_03FC, hit: 1'b1, bias: 1'b1, exp_pred: 1'b1, exp_idx: 8'hFF};
        vecs[4] = '{pc: 32'h0000_0400, hit: 1'b1, bias: 1'b0, exp_pred: 1'b0, exp_idx: 8'h00};
        vecs[5] = '{pc: 32'hFFFF_FFFF, hit: 1'b1, bias: 1'b1, exp_pred: 1'b1, exp_idx: 8'hFF};

        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Fresh table: every counter weak-agree, history zero
        foreach (vecs[i]) begin
            idle();
            bus.pc_i      = vecs[i].pc;
            bus.btb_hit_i = vecs[i].hit;
            bus.bias_i    = vecs[i].bias;
            #1;
            check("vec_pred", 32'(bus.pred_taken_o), 32'(vecs[i].exp_pred));
            check("vec_idx", 32'(bus.pred_index_o), 32'(vecs[i].exp_idx));
            check("vec_ghr", 32'(bus.ghr_o), 32'h0);
            cycle();
        end

        // Saturation at both ends of counter 5
        train(5, 1'b1, 1'b0, 3);
        probe("sat_low", 32'h14, 1'b1, 1'b0);
        train(5, 1'b1, 1'b1, 4);
        probe("sat_agree", 32'h14, 1'b1, 1'b1);
        train(5, 1'b1, 1'b0, 1);
        probe("sat_high", 32'h14, 1'b1, 1'b1);
        train(5, 1'b1, 1'b0, 1);
        probe("sat_down", 32'h14, 1'b1, 1'b0);

        // Speculative shift with a stalled middle fetch, then a BTB miss
        do_reset();
        bus.fetch_valid_i = 1'b1;
        bus.btb_hit_i     = 1'b1;
        bus.bias_i        = 1'b1;
        bus.pc_i          = 32'h100;
        cycle();
        bus.stall_i = 1'b1;
        cycle();
        bus.stall_i = 1'b0;
        cycle();
        bus.btb_hit_i = 1'b0;
        #1;
        check("ghr_shift", 32'(bus.ghr_o), 32'h03);
        cycle();
        idle();
        #1;
        check("ghr_miss_hold", 32'(bus.ghr_o), 32'h03);

        // Recovery collides with a speculative shift
        bus.fetch_valid_i = 1'b1;
        bus.btb_hit_i     = 1'b1;
        bus.bias_i        = 1'b1;
        bus.pc_i          = 32'h100;
        bus.upd_valid_i   = 1'b1;
        bus.upd_mispred_i = 1'b1;
        bus.upd_index_i   = 8'd9;
        bus.upd_ghr_i     = 8'hA5;
        bus.upd_taken_i   = 1'b0;
        cycle();
        idle();
        #1;
        check("ghr_recover", 32'(bus.ghr_o), 32'h4A);

        // Alloc read-during-write, then reset beating an update
        train(7, 1'b1, 1'b0, 2);
        bus.upd_valid_i = 1'b1;
        bus.upd_alloc_i = 1'b1;
        bus.upd_index_i = 8'd7;
        bus.upd_bias_i  = 1'b1;
        bus.upd_taken_i = 1'b1;
        probe("raw_old", 32'((7 ^ m_ghr) << 2), 1'b1, 1'b0);
        probe("alloc_weak", 32'((7 ^ m_ghr) << 2), 1'b1, 1'b1);
        bus.upd_valid_i   = 1'b1;
        bus.upd_index_i   = 8'd7;
        bus.upd_bias_i    = 1'b1;
        bus.upd_taken_i   = 1'b0;
        bus.upd_mispred_i = 1'b1;
        bus.upd_ghr_i     = 8'hFF;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle();
        #1;
        check("rst_ghr", 32'(bus.ghr_o), 32'h0);
        probe("rst_cnt", 32'h1C, 1'b1, 1'b1);

`ifdef AGREE_PHT_STATS_EN
        do_reset();
        for (int k = 0; k < 10; k++) begin
            idle();
            bus.fetch_valid_i = 1'b1;
            bus.btb_hit_i     = 1'b1;
            bus.pc_i          = 32'(k * 4);
            bus.upd_valid_i   = (k == 3 || k == 7);
            bus.upd_mispred_i = (k == 3 || k == 7);
            cycle();
        end
        idle();
        #1;
        check("stats_lookups", stat_lookups, 32'd10);
        check("stats_mispred", stat_mispred, 32'd2);
        cycle();
`endif

        // Random traffic; narrow update index range to force collisions
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst               = ($urandom_range(0, 99) == 0);
            bus.fetch_valid_i = 1'($urandom_range(0, 3) != 0);
            bus.stall_i       = 1'($urandom_range(0, 3) == 0);
            bus.pc_i          = $urandom & 32'h0000_00FC;
            bus.btb_hit_i     = 1'($urandom_range(0, 3) != 0);
            bus.bias_i        = 1'($urandom);
            bus.upd_valid_i   = 1'($urandom);
            bus.upd_alloc_i   = 1'($urandom_range(0, 3) == 0);
            bus.upd_index_i   = IW'($urandom_range(0, 63));
            bus.upd_bias_i    = 1'($urandom);
            bus.upd_taken_i   = 1'($urandom);
            bus.upd_mispred_i = 1'($urandom_range(0, 2) == 0);
            bus.upd_ghr_i     = GW'($urandom);
            cycle();
        end
        rst = 1'b0;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
